// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle for alu_seq.
// master = requester (decode stage), slave = the ALU.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_operand1;
   logic [WIDTH-1:0] alu_operand2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_ovf;
   logic             flag_neg;
   logic             flag_div0;
   logic             flag_illegal;

   modport master (
      output in_valid, alu_op, alu_operand1, alu_operand2, out_ready,
      input  in_ready, out_valid, alu_out,
      input  flag_zero, flag_carry, flag_ovf, flag_neg, flag_div0, flag_illegal
   );

   modport slave (
      input  in_valid, alu_op, alu_operand1, alu_operand2, out_ready,
      output in_ready, out_valid, alu_out,
      output flag_zero, flag_carry, flag_ovf, flag_neg, flag_div0, flag_illegal
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake and status flags.
// Single-cycle ops: ADD, SUB, NOT, AND, OR, XOR. Unknown opcodes flag illegal.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/DIV/MOD datapath;
// without it, opcodes 2-4 are illegal and the FSM is IDLE/DONE only.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);
   localparam int unsigned Msb = WIDTH - 1;

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpNot = 4'd5;
   localparam logic [3:0] OpAnd = 4'd6;
   localparam logic [3:0] OpOr  = 4'd7;
   localparam logic [3:0] OpXor = 4'd8;

`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [3:0] OpMul = 4'd2;
   localparam logic [3:0] OpDiv = 4'd3;
   localparam logic [3:0] OpMod = 4'd4;
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
   typedef enum logic {StIdle, StDone} state_e;
`endif

   state_e           state_q;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] res_q;
   logic             zero_q, carry_q, ovf_q, neg_q, div0_q, ill_q;

   logic [WIDTH-1:0] a, b;
   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry, sc_ovf, sc_ill;

   assign a     = bus.alu_operand1;
   assign b     = bus.alu_operand2;
   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};

   // Single-cycle result and flags, straight from the live operands.
   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      sc_ill   = 1'b0;
      case (bus.alu_op)
         OpAdd: begin
            sc_res   = add_w[Msb:0];
            sc_carry = add_w[WIDTH];
            sc_ovf   = (a[Msb] == b[Msb]) && (add_w[Msb] != a[Msb]);
         end
         OpSub: begin
            sc_res   = sub_w[Msb:0];
            sc_carry = sub_w[WIDTH];  // borrow
            sc_ovf   = (a[Msb] != b[Msb]) && (sub_w[Msb] != a[Msb]);
         end
         OpNot:   sc_res = ~a;
         OpAnd:   sc_res = a & b;
         OpOr:    sc_res = a | b;
         OpXor:   sc_res = a ^ b;
         default: sc_ill = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   // hi/lo: MUL = {partial product, remaining multiplier}; DIV/MOD = {remainder, quotient}.
   // opb holds the multiplicand (MUL) or divisor (DIV/MOD).
   logic [WIDTH-1:0] hi_q, lo_q, opb_q, hi_nx, lo_nx, it_res;
   logic [3:0]       op_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic             is_iter;

   assign is_iter = (bus.alu_op == OpMul) || (bus.alu_op == OpDiv) || (bus.alu_op == OpMod);

   // One shift-add or restoring-divide step. Divisor 0 never restores, giving
   // quotient all-ones and remainder A without any special casing.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_sh   = {hi_q, lo_q[Msb]};
      div_diff = div_sh - {1'b0, opb_q};
      if (op_q == OpMul) begin
         hi_nx = mul_sum[WIDTH:1];
         lo_nx = {mul_sum[0], lo_q[Msb:1]};
      end else if (!div_diff[WIDTH]) begin
         hi_nx = div_diff[Msb:0];
         lo_nx = {lo_q[Msb-1:0], 1'b1};
      end else begin
         hi_nx = {hi_q[Msb-1:0], lo_q[Msb]};
         lo_nx = {lo_q[Msb-1:0], 1'b0};
      end
      it_res = (op_q == OpMod) ? hi_nx : lo_nx;
   end
`endif

   // Control FSM; all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         neg_q       <= 1'b0;
         div0_q      <= 1'b0;
         ill_q       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         hi_q        <= '0;
         lo_q        <= '0;
         opb_q       <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
                  if (is_iter) begin
                     op_q    <= bus.alu_op;
                     opb_q   <= (bus.alu_op == OpMul) ? a : b;
                     lo_q    <= (bus.alu_op == OpMul) ? b : a;
                     hi_q    <= '0;
                     cnt_q   <= CntW'(WIDTH - 1);
                     state_q <= StBusy;
                  end else
`endif
                  begin
                     res_q       <= sc_res;
                     zero_q      <= (sc_res == '0);
                     neg_q       <= sc_res[Msb];
                     carry_q     <= sc_carry;
                     ovf_q       <= sc_ovf;
                     div0_q      <= 1'b0;
                     ill_q       <= sc_ill;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
               end
            end
`ifdef ALU_SEQ_MULDIV_EN
            StBusy: begin
               hi_q <= hi_nx;
               lo_q <= lo_nx;
               if (cnt_q == '0) begin
                  res_q       <= it_res;
                  zero_q      <= (it_res == '0);
                  neg_q       <= it_res[Msb];
                  carry_q     <= (op_q == OpMul) && (hi_nx != '0);
                  ovf_q       <= 1'b0;
                  div0_q      <= (op_q != OpMul) && (opb_q == '0);
                  ill_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
`endif
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.alu_out      = res_q;
   assign bus.flag_zero    = zero_q;
   assign bus.flag_carry   = carry_q;
   assign bus.flag_ovf     = ovf_q;
   assign bus.flag_neg     = neg_q;
   assign bus.flag_div0    = div0_q;
   assign bus.flag_illegal = ill_q;
endmodule
